// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and default widths for alu_exec_unit.
// The DIV/FIX/OUT states exist only when ALU_DIV_EN is defined.
package alu_pkg;

  localparam int ALU_XLEN  = 32;
  localparam int ALU_TAG_W = 4;
  localparam int ALU_OP_W  = 5;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_AND   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_XOR   = 4;
  localparam int OP_SLL   = 5;
  localparam int OP_SRL   = 6;
  localparam int OP_SRA   = 7;
  localparam int OP_SLT   = 8;
  localparam int OP_SLTU  = 9;
  localparam int OP_EQ    = 10;
  localparam int OP_NE    = 11;
  localparam int OP_SGE   = 12;
  localparam int OP_SGEU  = 13;
  localparam int OP_SLT2  = 14;
  localparam int OP_SLTU2 = 15;
  localparam int OP_MUL   = 16;
  localparam int OP_DIV   = 17;
  localparam int OP_DIVU  = 18;
  localparam int OP_REM   = 19;
  localparam int OP_REMU  = 20;

  typedef logic [1:0] alu_state_t;

  localparam alu_state_t ST_IDLE = 2'd0;
`ifdef ALU_DIV_EN
  localparam alu_state_t ST_DIV  = 2'd1;
  localparam alu_state_t ST_FIX  = 2'd2;
  localparam alu_state_t ST_OUT  = 2'd3;
`endif

  function automatic logic is_div_op(input int op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_exec_unit_div.sv
// alu_div_iter: restoring divider, one quotient bit per cycle, then one sign-fix cycle.
// Only compiled when ALU_DIV_EN is defined.
`ifdef ALU_DIV_EN
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            start,
  input  logic            signed_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            last,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  logic [CW-1:0]   cnt;
  logic            busy_q, fix_q, done_q;
  logic            neg_q, neg_r, dz_q;
  logic [XLEN-1:0] quo, rem, dvs, a_raw;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   shifted, trial;

  assign a_neg   = signed_op & a[XLEN-1];
  assign b_neg   = signed_op & b[XLEN-1];
  assign a_abs   = a_neg ? (~a + ONE) : a;
  assign b_abs   = b_neg ? (~b + ONE) : b;
  assign shifted = {rem, quo[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      busy_q <= 1'b0;
      fix_q  <= 1'b0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      a_raw  <= '0;
    end else if (kill) begin
      cnt    <= '0;
      busy_q <= 1'b0;
      fix_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        quo    <= a_abs;
        rem    <= '0;
        dvs    <= b_abs;
        a_raw  <= a;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        dz_q   <= (b == '0);
        cnt    <= CW'(XLEN);
        busy_q <= 1'b1;
        fix_q  <= 1'b0;
      end else if (fix_q) begin
        // Divide-by-zero keeps full latency but forces all-ones / dividend.
        quo    <= dz_q ? '1 : (neg_q ? (~quo + ONE) : quo);
        rem    <= dz_q ? a_raw : (neg_r ? (~rem + ONE) : rem);
        fix_q  <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else if (busy_q) begin
        if (trial[XLEN]) begin
          rem <= shifted[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b0};
        end else begin
          rem <= trial[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b1};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) fix_q <= 1'b1;
      end
    end
  end

  assign busy      = busy_q;
  assign last      = busy_q && !fix_q && (cnt == CW'(1));
  assign done      = done_q;
  assign quotient  = quo;
  assign remainder = rem;

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU with registered CDB output and optional iterative divider.
// Define ALU_DIV_EN to build the divider (opcodes 17-20); otherwise those opcodes report err.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int TAG_W = ALU_TAG_W,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [TAG_W-1:0] tag,
  output logic             cdb_alu_done,
  input  logic             cdb_ready,
  output logic [XLEN-1:0]  cdb_alu_data,
  output logic [TAG_W-1:0] cdb_alu_tag,
  output logic             cdb_alu_err,
  output logic [1:0]       dbg_state
);

  // Handshake: issue is taken on a rising edge where in_valid && in_ready;
  // a CDB result is retired on a rising edge where cdb_alu_done && cdb_ready.
  // Data/tag/err never change while done is high and not yet retired.

  localparam int SH_W = $clog2(XLEN);

  alu_state_t      state;
  logic            init_done;
  logic            done_q, err_q;
  logic [XLEN-1:0] data_q;
  logic [TAG_W-1:0] tag_q;
  int              op_i;
  logic            accept, issue_div, issue_single, div_busy;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] res;
  logic            known;

  function automatic logic [XLEN-1:0] zext1(input logic v);
    return {{(XLEN-1){1'b0}}, v};
  endfunction

  assign op_i  = int'(alu_op);
  assign shamt = b[SH_W-1:0];

  always_comb begin
    res   = '0;
    known = 1'b1;
    case (op_i)
      OP_ADD:            res = a + b;
      OP_SUB:            res = a - b;
      OP_AND:            res = a & b;
      OP_OR:             res = a | b;
      OP_XOR:            res = a ^ b;
      OP_SLL:            res = a << shamt;
      OP_SRL:            res = a >> shamt;
      OP_SRA:            res = XLEN'($signed(a) >>> shamt);
      OP_SLT, OP_SLT2:   res = zext1($signed(a) < $signed(b));
      OP_SLTU, OP_SLTU2: res = zext1(a < b);
      OP_EQ:             res = zext1(a == b);
      OP_NE:             res = zext1(a != b);
      OP_SGE:            res = zext1($signed(a) >= $signed(b));
      OP_SGEU:           res = zext1(a >= b);
      OP_MUL:            res = a * b;
      default:           known = 1'b0;
    endcase
  end

`ifdef ALU_DIV_EN
  logic            div_last, div_done, pend_rem;
  logic [XLEN-1:0] div_q, div_r;
  logic [TAG_W-1:0] pend_tag;

  assign issue_div = accept && is_div_op(op_i);

  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (flush),
    .start     (issue_div),
    .signed_op ((op_i == OP_DIV) || (op_i == OP_REM)),
    .a         (a),
    .b         (b),
    .busy      (div_busy),
    .last      (div_last),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`else
  assign issue_div = 1'b0;
  assign div_busy  = 1'b0;
`endif

  assign in_ready = init_done && (state == ST_IDLE) && !div_busy &&
                    (!done_q || cdb_ready) && !flush;
  assign accept       = in_valid && in_ready;
  assign issue_single = accept && !issue_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      init_done <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      tag_q     <= '0;
`ifdef ALU_DIV_EN
      pend_tag  <= '0;
      pend_rem  <= 1'b0;
`endif
    end else begin
      init_done <= 1'b1;
      if (flush) begin
        state  <= ST_IDLE;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        if (done_q && cdb_ready) done_q <= 1'b0;
        if (issue_single) begin
          data_q <= known ? res : '0;
          tag_q  <= tag;
          err_q  <= !known;
          done_q <= 1'b1;
        end
`ifdef ALU_DIV_EN
        if (issue_div) begin
          state    <= ST_DIV;
          pend_tag <= tag;
          pend_rem <= (op_i == OP_REM) || (op_i == OP_REMU);
        end
        // FIX covers the divider's correction cycle and the hand-off into the CDB register.
        case (state)
          ST_DIV: if (div_last) state <= ST_FIX;
          ST_FIX: begin
            if (div_done) begin
              data_q <= pend_rem ? div_r : div_q;
              tag_q  <= pend_tag;
              err_q  <= 1'b0;
              done_q <= 1'b1;
              state  <= ST_OUT;
            end
          end
          ST_OUT: if (cdb_ready) state <= ST_IDLE;
          default: ;
        endcase
`endif
      end
    end
  end

  assign cdb_alu_done = done_q;
  assign cdb_alu_err  = err_q;
  assign cdb_alu_data = data_q;
  assign cdb_alu_tag  = tag_q;
  assign dbg_state    = state;

endmodule
